rom_load_buffer: RTL and testbench

// - Sits between data_io (ioctl byte stream) and the sdram address/data/we muxes.
// - Buffers downloaded ROM/disk bytes and relocates each by ioctl_index.
//   - index 0 -> Model B/MOS ROM region.
//   - any other index -> Master ROM region.
// - Issues exactly one SDRAM write per mem_sync slot.
// - Holds the core in reset via loader_active until the last byte is committed.

---
 rtl/bbc_load_pkg.sv | 19 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/rom_load_buffer.sv | 109 ++++++++++
 tb/tb_rom_load_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bbc_load_pkg.sv
// Shared constants and the buffered-write entry type for the ROM download path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default SDRAM byte-address width, relocation bases and the
// {addr, data} entry carried through the loader byte buffer.
package bbc_load_pkg;

   localparam int LOAD_ADDR_W = 25;

   // Image 0 is the Model B / MOS ROM set; every other image is Master ROM.
   localparam logic [LOAD_ADDR_W-1:0] LOAD_BASE_IDX0  = 25'h80000;
   localparam logic [LOAD_ADDR_W-1:0] LOAD_BASE_OTHER = 25'h68000;

   typedef struct packed {
      logic [LOAD_ADDR_W-1:0] addr;
      logic [7:0]             data;
   } load_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational head output.
// Latency: a pushed entry is visible at pop_dat one cycle after the push.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk/rst_n, push_vld/push_dat (write side), pop_rdy/pop_dat (read side),
// full/empty status. DEPTH must be a power of two, at least 2.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop_rdy & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_vld & (~full | do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset: the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/rom_load_buffer.sv
// Buffers data_io download bytes, relocates them by image index and issues one SDRAM write per mem_sync slot.
// Latency: a byte pushed into an empty buffer is driven on loader_* at the first mem_sync after the push cycle.
// Backpressure: none upstream; a byte arriving while the buffer is full with no pop is dropped and flagged in overflow.
// Ports: clk_sys/rst_n; mem_sync slot pulse; ioctl_* download stream in;
// loader_we/addr/data SDRAM write request out; loader_active core-reset hold;
// load_count committed-byte counter; overflow sticky drop flag.
module rom_load_buffer
   import bbc_load_pkg::*;
#(
   parameter int                FIFO_DEPTH = 8,
   parameter int                ADDR_W     = LOAD_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_IDX0  = LOAD_BASE_IDX0,
   parameter logic [ADDR_W-1:0] BASE_OTHER = LOAD_BASE_OTHER
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              mem_sync,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              loader_active,
   output logic              loader_we,
   output logic [ADDR_W-1:0] loader_addr,
   output logic [7:0]        loader_data,
   output logic [ADDR_W-1:0] load_count,
   output logic              overflow
);

   load_entry_t       push_entry;
   load_entry_t       head_entry;
   logic [ADDR_W-1:0] reloc_base;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              drop;
   logic              download_q;
   logic              download_start;

   // Relocation adder; wraps modulo 2^ADDR_W by construction.
   assign reloc_base      = (ioctl_index == 8'd0) ? BASE_IDX0 : BASE_OTHER;
   assign push_entry.addr = ioctl_addr + reloc_base;
   assign push_entry.data = ioctl_dout;

   // Pops are only allowed on slot boundaries, so the SDRAM sees at most
   // one write per slot.
   assign pop  = mem_sync & ~fifo_empty;
   assign drop = ioctl_wr & fifo_full & ~pop;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(load_entry_t))
   ) u_fifo (
      .clk      (clk_sys),
      .rst_n    (rst_n),
      .push_vld (ioctl_wr),
      .push_dat (push_entry),
      .pop_rdy  (pop),
      .pop_dat  (head_entry),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign download_start = ioctl_download & ~download_q;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         download_q <= 1'b0;
      end else begin
         download_q <= ioctl_download;
      end
   end

   // Slot-issue register: loader_we is only re-evaluated on mem_sync so the
   // request is held stable for the whole slot; addr/data keep their last
   // value through idle slots.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         loader_we   <= 1'b0;
         loader_addr <= '0;
         loader_data <= '0;
      end else if (mem_sync) begin
         loader_we <= ~fifo_empty;
         if (!fifo_empty) begin
            loader_addr <= head_entry.addr;
            loader_data <= head_entry.data;
         end
      end
   end

   // A new download restarts the statistics but leaves queued bytes alone.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         load_count <= '0;
         overflow   <= 1'b0;
      end else if (download_start) begin
         load_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (pop)  load_count <= load_count + 1'b1;
         if (drop) overflow   <= 1'b1;
      end
   end

   // loader_we keeps this high through the slot carrying the final write.
   assign loader_active = ioctl_download | ~fifo_empty | loader_we;

endmodule

// File: tb/tb_rom_load_buffer.sv
// Directed bench for rom_load_buffer: relocation, slot timing, overflow, drain tail and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_load_buffer;

   localparam int AW = 25;

   logic          clk_sys = 1'b0;
   logic          rst_n;
   logic          mem_sync;
   logic          ioctl_download;
   logic [7:0]    ioctl_index;
   logic          ioctl_wr;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          loader_active;
   logic          loader_we;
   logic [AW-1:0] loader_addr;
   logic [7:0]    loader_data;
   logic [AW-1:0] load_count;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   always #10 clk_sys = ~clk_sys;

   rom_load_buffer dut (
      .clk_sys        (clk_sys),
      .rst_n          (rst_n),
      .mem_sync       (mem_sync),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .loader_active  (loader_active),
      .loader_we      (loader_we),
      .loader_addr    (loader_addr),
      .loader_data    (loader_data),
      .load_count     (load_count),
      .overflow       (overflow)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] idx, input logic [AW-1:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
      tick();
      ioctl_wr = 1'b0;
   endtask

   // One slot pulse followed by an idle cycle.
   task automatic slot();
      mem_sync = 1'b1;
      tick();
      mem_sync = 1'b0;
      tick();
   endtask

   task automatic restart_download();
      ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_sync = 1'b0; ioctl_download = 1'b0; ioctl_index = '0;
      ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
      tick(); tick();
      checks++; if (loader_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h expected 0", loader_we); end
      checks++; if (loader_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", loader_addr); end
      checks++; if (loader_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", loader_data); end
      checks++; if (load_count !== '0) begin errors++; $display("FAIL reset_count: got %0h expected 0", load_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0h expected 0", overflow); end
      checks++; if (loader_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0h expected 0", loader_active); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_index0();
      restart_download();
      wr_byte(8'd0, 25'h0010, 8'hA5);
      checks++; if (loader_we !== 1'b0) begin errors++; $display("FAIL idx0_we_before_slot: got %0h expected 0", loader_we); end
      checks++; if (loader_active !== 1'b1) begin errors++; $display("FAIL idx0_active: got %0h expected 1", loader_active); end
      slot();
      checks++; if (loader_we !== 1'b1) begin errors++; $display("FAIL idx0_we: got %0h expected 1", loader_we); end
      checks++; if (loader_addr !== 25'h80010) begin errors++; $display("FAIL idx0_addr: got %0h expected 80010", loader_addr); end
      checks++; if (loader_data !== 8'hA5) begin errors++; $display("FAIL idx0_data: got %0h expected a5", loader_data); end
      checks++; if (load_count !== 25'd1) begin errors++; $display("FAIL idx0_count: got %0d expected 1", load_count); end
      slot();
      checks++; if (loader_we !== 1'b0) begin errors++; $display("FAIL idx0_we_idle: got %0h expected 0", loader_we); end
      checks++; if (loader_addr !== 25'h80010) begin errors++; $display("FAIL idx0_addr_hold: got %0h expected 80010", loader_addr); end
   endtask

   task automatic test_index1();
      wr_byte(8'd1, 25'h4000, 8'h3C);
      slot();
      checks++; if (loader_addr !== 25'h6C000) begin errors++; $display("FAIL idx1_addr: got %0h expected 6c000", loader_addr); end
      checks++; if (loader_data !== 8'h3C) begin errors++; $display("FAIL idx1_data: got %0h expected 3c", loader_data); end
      checks++; if (load_count !== 25'd2) begin errors++; $display("FAIL idx1_count: got %0d expected 2", load_count); end
      slot();
   endtask

   task automatic test_same_cycle();
      ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 25'h0123; ioctl_dout = 8'h5A;
      mem_sync = 1'b1;
      tick();
      ioctl_wr = 1'b0; mem_sync = 1'b0;
      tick();
      checks++; if (loader_we !== 1'b0) begin errors++; $display("FAIL same_cycle_we_first: got %0h expected 0", loader_we); end
      slot();
      checks++; if (loader_we !== 1'b1) begin errors++; $display("FAIL same_cycle_we_next: got %0h expected 1", loader_we); end
      checks++; if (loader_addr !== 25'h80123) begin errors++; $display("FAIL same_cycle_addr: got %0h expected 80123", loader_addr); end
      slot();
   endtask

   task automatic test_burst_overflow();
      restart_download();
      checks++; if (load_count !== '0) begin errors++; $display("FAIL burst_count_cleared: got %0d expected 0", load_count); end
      for (int i = 0; i < 8; i++) wr_byte(8'd0, 25'(i), 8'(8'h10 + i));
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_no_overflow: got %0h expected 0", overflow); end
      wr_byte(8'd0, 25'h100, 8'hFF);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow: got %0h expected 1", overflow); end
      checks++; if (load_count !== '0) begin errors++; $display("FAIL burst_count_on_drop: got %0d expected 0", load_count); end
      for (int i = 0; i < 8; i++) begin
         slot();
         checks++; if (loader_we !== 1'b1 || loader_addr !== 25'(25'h80000 + i) || loader_data !== 8'(8'h10 + i)) begin
            errors++; $display("FAIL burst_write_%0d: got we=%0h addr=%0h data=%0h expected we=1 addr=%0h data=%0h",
                                i, loader_we, loader_addr, loader_data, 25'h80000 + i, 8'h10 + i);
         end
      end
      slot();
      checks++; if (loader_we !== 1'b0) begin errors++; $display("FAIL burst_no_ninth: got %0h expected 0", loader_we); end
      checks++; if (load_count !== 25'd8) begin errors++; $display("FAIL burst_count: got %0d expected 8", load_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow_sticky: got %0h expected 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      restart_download();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow_cleared: got %0h expected 0", overflow); end
      for (int i = 0; i < 8; i++) wr_byte(8'd2, 25'(i), 8'(8'h20 + i));
      ioctl_wr = 1'b1; ioctl_index = 8'd2; ioctl_addr = 25'h8; ioctl_dout = 8'h77;
      mem_sync = 1'b1;
      tick();
      ioctl_wr = 1'b0; mem_sync = 1'b0;
      tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_drop: got %0h expected 0", overflow); end
      checks++; if (loader_data !== 8'h20) begin errors++; $display("FAIL fpp_first: got %0h expected 20", loader_data); end
      for (int i = 1; i < 9; i++) slot();
      checks++; if (loader_addr !== 25'h68008 || loader_data !== 8'h77) begin
         errors++; $display("FAIL fpp_last: got addr=%0h data=%0h expected addr=68008 data=77", loader_addr, loader_data);
      end
      checks++; if (load_count !== 25'd9) begin errors++; $display("FAIL fpp_count: got %0d expected 9", load_count); end
      slot();
   endtask

   task automatic test_drain_tail();
      for (int i = 0; i < 3; i++) wr_byte(8'd0, 25'(16'h200 + i), 8'(8'hC0 + i));
      ioctl_download = 1'b0;
      tick();
      checks++; if (loader_active !== 1'b1) begin errors++; $display("FAIL drain_active_queued: got %0h expected 1", loader_active); end
      for (int i = 0; i < 3; i++) begin
         slot();
         checks++; if (loader_we !== 1'b1 || loader_active !== 1'b1 || loader_data !== 8'(8'hC0 + i)) begin
            errors++; $display("FAIL drain_slot_%0d: got we=%0h active=%0h data=%0h expected we=1 active=1 data=%0h",
                                i, loader_we, loader_active, loader_data, 8'hC0 + i);
         end
      end
      slot();
      checks++; if (loader_active !== 1'b0) begin errors++; $display("FAIL drain_active_end: got %0h expected 0", loader_active); end
      checks++; if (loader_we !== 1'b0) begin errors++; $display("FAIL drain_we_end: got %0h expected 0", loader_we); end
   endtask

   task automatic test_reset_mid();
      restart_download();
      for (int i = 0; i < 5; i++) wr_byte(8'd0, 25'(16'h300 + i), 8'(8'hE0 + i));
      slot();
      checks++; if (loader_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we: got %0h expected 1", loader_we); end
      rst_n = 1'b0; ioctl_download = 1'b0;
      #1;
      checks++; if (loader_we !== 1'b0 || loader_addr !== '0 || loader_data !== 8'h00) begin
         errors++; $display("FAIL midrst_outputs: got we=%0h addr=%0h data=%0h expected all 0", loader_we, loader_addr, loader_data);
      end
      checks++; if (load_count !== '0 || overflow !== 1'b0 || loader_active !== 1'b0) begin
         errors++; $display("FAIL midrst_status: got count=%0d ovf=%0h active=%0h expected all 0", load_count, overflow, loader_active);
      end
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         slot();
         checks++; if (loader_we !== 1'b0 || loader_active !== 1'b0) begin
            errors++; $display("FAIL midrst_after_%0d: got we=%0h active=%0h expected 0 0", i, loader_we, loader_active);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_index0();
      test_index1();
      test_same_cycle();
      test_burst_overflow();
      test_full_push_pop();
      test_drain_tail();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
